// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the SRAM load/store stage: FSM encoding,
// strobe bundle, byte-lane enable and load-extract functions.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  // Registered SRAM control strobes, all active-low except dq_oe.
  typedef struct packed {
    logic            ce_n;
    logic            oe_n;
    logic            we_n;
    logic            dq_oe;
    logic [BE_W-1:0] be_n;
  } strobe_t;

  localparam strobe_t STRB_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                    dq_oe: 1'b0, be_n: {BE_W{1'b1}}};

  // Active-low byte enables: all lanes for a word, one lane for a byte.
  function automatic logic [BE_W-1:0] lane_be_n(input logic              byte_acc,
                                                 input logic [LANE_W-1:0] lane);
    logic [BE_W-1:0] sel;
    sel = BE_W'(1) << lane;
    return byte_acc ? ~sel : {BE_W{1'b0}};
  endfunction

  // Store data as driven on the bus; a byte is replicated into every lane.
  function automatic logic [DATA_W-1:0] store_data(input logic              byte_acc,
                                                   input logic [DATA_W-1:0] data);
    return byte_acc ? {4{data[7:0]}} : data;
  endfunction

  // Load result: whole word, or the addressed lane sign-extended from bit 7.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic              byte_acc,
                                                     input logic [LANE_W-1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return byte_acc ? {{(DATA_W-8){b[7]}}, b} : word;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Asynchronous SRAM bus with split data lines; master is the memory stage.
interface mem_access_if
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 20
) ();

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dq_o;
  logic              ram_dq_oe;
  logic [DATA_W-1:0] ram_dq_i;
  logic [BE_W-1:0]   ram_be_n;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  modport master (
    output ram_addr, ram_dq_o, ram_dq_oe, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
    input  ram_dq_i
  );

  modport slave (
    input  ram_addr, ram_dq_o, ram_dq_oe, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
    output ram_dq_i
  );

endinterface

// File: rtl/mem_access.sv
// Pipeline memory stage: runs LW/LB/SW/SB against an asynchronous SRAM with a
// programmable strobe width, stalls upstream while busy, and feeds writeback.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_mem_data,
  input  logic              ex_load_byte,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_W-1:0]  ex_write_reg,
  output logic              mem_stall,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [DATA_W-1:0] wb_data,
  mem_access_if.master      ram
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  strobe_t           strobe_q, strobe_d;
  logic              capture_rd, capture_wr, rd_last;
  logic [BE_W-1:0]   be_sel;

  logic              byte_q;
  logic [LANE_W-1:0] lane_q;
  logic [REG_W-1:0]  dest_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_o_q;

  // State, wait counter and strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      strobe_q <= STRB_IDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Next state, stall, and strobes decoded from the state being entered so
  // the registered strobes line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    strobe_d   = STRB_IDLE;
    mem_stall  = 1'b0;
    capture_rd = 1'b0;
    capture_wr = 1'b0;
    rd_last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_mem_read) begin
          mem_stall  = 1'b1;
          capture_rd = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RD;
        end else if (ex_mem_write) begin
          mem_stall  = 1'b1;
          capture_wr = 1'b1;
          cnt_d      = '0;
          state_d    = ST_WR_SETUP;
        end
      end
      ST_RD: begin
        mem_stall = 1'b1;
        if (cnt_q == LAST_CNT) begin
          rd_last = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        mem_stall = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        mem_stall = 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        mem_stall = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    be_sel = (capture_rd || capture_wr) ? lane_be_n(ex_load_byte, ex_result[1:0])
                                        : lane_be_n(byte_q, lane_q);

    case (state_d)
      ST_RD: begin
        strobe_d.ce_n = 1'b0;
        strobe_d.oe_n = 1'b0;
        strobe_d.be_n = be_sel;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        strobe_d.ce_n  = 1'b0;
        strobe_d.dq_oe = 1'b1;
        strobe_d.be_n  = be_sel;
      end
      ST_WR_PULSE: begin
        strobe_d.ce_n  = 1'b0;
        strobe_d.we_n  = 1'b0;
        strobe_d.dq_oe = 1'b1;
        strobe_d.be_n  = be_sel;
      end
      default: strobe_d = STRB_IDLE;
    endcase
  end

  // Access capture and writeback registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      dq_o_q       <= '0;
      byte_q       <= 1'b0;
      lane_q       <= '0;
      dest_q       <= '0;
      wb_reg_write <= 1'b0;
      wb_write_reg <= '0;
      wb_data      <= '0;
    end else begin
      if (capture_rd || capture_wr) begin
        addr_q <= ex_result[ADDR_W+1:2];
        byte_q <= ex_load_byte;
        lane_q <= ex_result[1:0];
        dest_q <= ex_write_reg;
      end
      if (capture_wr) begin
        dq_o_q <= store_data(ex_load_byte, ex_mem_data);
      end

      if (state_q == ST_IDLE && !ex_mem_read && !ex_mem_write) begin
        wb_reg_write <= ex_reg_write && (ex_write_reg != '0);
        wb_write_reg <= ex_write_reg;
        wb_data      <= ex_result;
      end else if (rd_last) begin
        wb_reg_write <= (dest_q != '0);
        wb_write_reg <= dest_q;
        wb_data      <= load_extract(ram.ram_dq_i, byte_q, lane_q);
      end else begin
        wb_reg_write <= 1'b0;
      end
    end
  end

  assign ram.ram_addr  = addr_q;
  assign ram.ram_dq_o  = dq_o_q;
  assign ram.ram_dq_oe = strobe_q.dq_oe;
  assign ram.ram_be_n  = strobe_q.be_n;
  assign ram.ram_ce_n  = strobe_q.ce_n;
  assign ram.ram_oe_n  = strobe_q.oe_n;
  assign ram.ram_we_n  = strobe_q.we_n;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a behavioural async SRAM and a
// writeback scoreboard (WAIT_CYCLES = 1).
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int unsigned ADDR_W = 20;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] ex_result, ex_mem_data;
  logic        ex_load_byte, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [4:0]  ex_write_reg;
  logic        mem_stall, wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;

  int tests  = 0;
  int fails  = 0;
  int overlap = 0;
  int bad_wb = 0;

  wb_exp_t sb_q[$];

  int                mo_stall, mo_we_low, mo_we_at, mo_oe;
  logic [3:0]        mo_be;
  logic [31:0]       mo_dq;
  logic [ADDR_W-1:0] mo_addr;

  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  mem_access_if #(.ADDR_W(ADDR_W)) ram_bus ();

  mem_access #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_result    (ex_result),
    .ex_mem_data  (ex_mem_data),
    .ex_load_byte (ex_load_byte),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write),
    .ex_write_reg (ex_write_reg),
    .mem_stall    (mem_stall),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .wb_data      (wb_data),
    .ram          (ram_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM: combinational read, byte-masked write while ce_n and we_n low.
  logic [31:0] sram [0:255];
  logic [7:0]  sram_idx;
  logic        sram_hit;
  assign sram_idx = ram_bus.ram_addr[7:0];
  assign sram_hit = ~|ram_bus.ram_addr[ADDR_W-1:8];

  always_comb begin
    ram_bus.ram_dq_i = (!ram_bus.ram_ce_n && !ram_bus.ram_oe_n && sram_hit)
                       ? sram[sram_idx] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (pl_en) begin
      sram[pl_idx] <= pl_val;
    end else if (!ram_bus.ram_ce_n && !ram_bus.ram_we_n && ram_bus.ram_dq_oe && sram_hit) begin
      for (int b = 0; b < 4; b++)
        if (!ram_bus.ram_be_n[b]) sram[sram_idx][8*b +: 8] <= ram_bus.ram_dq_o[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (!ram_bus.ram_oe_n && !ram_bus.ram_we_n) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    ex_result    = 32'h0;
    ex_mem_data  = 32'h0;
    ex_load_byte = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_reg_write = 1'b0;
    ex_write_reg = 5'd0;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(posedge clk); #1;
    pl_en  = 1'b0;
  endtask

  task automatic compare_wb(input string tag);
    wb_exp_t e;
    check({tag, " sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, " wb_reg_write"}, 32'(wb_reg_write), 32'(e.we));
      if (e.we) begin
        check({tag, " wb_write_reg"}, 32'(wb_write_reg), 32'(e.rd));
        check({tag, " wb_data"}, wb_data, e.data);
      end
    end
  endtask

  // One memory instruction from IDLE until its DONE cycle.
  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic byt,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] dest, input logic [31:0] exp_data);
    wb_exp_t e;
    logic    done;
    @(posedge clk); #1;
    ex_mem_read  = rd;
    ex_mem_write = wr;
    ex_load_byte = byt;
    ex_result    = addr;
    ex_mem_data  = data;
    ex_write_reg = dest;
    ex_reg_write = rd;
    e.we   = rd && (dest != 5'd0);
    e.rd   = dest;
    e.data = exp_data;
    sb_q.push_back(e);
    mo_stall = 0; mo_we_low = 0; mo_we_at = -1; mo_oe = 0;
    mo_be = 4'hF; mo_dq = 32'h0; mo_addr = '0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!ram_bus.ram_ce_n) mo_addr = ram_bus.ram_addr;
      if (!ram_bus.ram_we_n) begin
        mo_we_low++;
        if (mo_we_at < 0) mo_we_at = c;
        mo_be = ram_bus.ram_be_n;
        mo_dq = ram_bus.ram_dq_o;
      end
      if (ram_bus.ram_dq_oe) mo_oe++;
      if (c > 0 && mem_stall && wb_reg_write) bad_wb++;
      if (mem_stall) begin
        mo_stall++;
      end else begin
        done = 1'b1;
        compare_wb(tag);
        drive_nop();
      end
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    if (!done) begin
      drive_nop();
      sb_q.delete();
    end
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
    drive_nop();
    preload(8'd4, 32'h89AB_CDEF);
    preload(8'd8, 32'h1122_3344);

    // Reset state.
    @(negedge clk);
    check("rst wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst wb_write_reg", 32'(wb_write_reg), 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst mem_stall", 32'(mem_stall), 32'd0);
    check("rst ce_n", 32'(ram_bus.ram_ce_n), 32'd1);
    check("rst oe_n", 32'(ram_bus.ram_oe_n), 32'd1);
    check("rst we_n", 32'(ram_bus.ram_we_n), 32'd1);
    check("rst be_n", 32'(ram_bus.ram_be_n), 32'hF);
    check("rst dq_oe", 32'(ram_bus.ram_dq_oe), 32'd0);
    check("rst ram_addr", 32'(ram_bus.ram_addr), 32'd0);

    // ALU passthrough: dest 3 then dest 0, one-cycle latency, no stall.
    @(posedge clk); #1;
    rst_n = 1'b1;
    ex_reg_write = 1'b1; ex_write_reg = 5'd3; ex_result = 32'h7;
    sb_q.push_back('{we: 1'b1, rd: 5'd3, data: 32'h7});
    @(negedge clk);
    check("alu0 mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    ex_write_reg = 5'd0; ex_result = 32'h9;
    sb_q.push_back('{we: 1'b0, rd: 5'd0, data: 32'h9});
    @(negedge clk);
    check("alu1 mem_stall", 32'(mem_stall), 32'd0);
    compare_wb("alu dest3");
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    compare_wb("alu dest0");
    check("alu2 mem_stall", 32'(mem_stall), 32'd0);

    // LW from word 4.
    mem_op("lw 0x10", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd8, 32'h89AB_CDEF);
    check("lw ram_addr", 32'(mo_addr), 32'd4);
    check("lw stall cycles", 32'(mo_stall), 32'd2);
    check("lw we_low", 32'(mo_we_low), 32'd0);

    // LB lanes with sign extension.
    preload(8'd4, 32'h1234_80FF);
    mem_op("lb 0x11", 1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 5'd5, 32'hFFFF_FF80);
    check("lb stall cycles", 32'(mo_stall), 32'd2);
    mem_op("lb 0x13", 1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd6, 32'h0000_0012);
    mem_op("lb dest0", 1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd0, 32'h0);

    // SB lane 2 of word 8, then read the word back.
    mem_op("sb 0x22", 1'b0, 1'b1, 1'b1, 32'h22, 32'h0000_00A5, 5'd0, 32'h0);
    check("sb be_n", 32'(mo_be), 32'hB);
    check("sb dq_o", mo_dq, 32'hA5A5_A5A5);
    check("sb we_low cycles", 32'(mo_we_low), 32'd1);
    check("sb we_low position", 32'(mo_we_at), 32'd2);
    check("sb dq_oe cycles", 32'(mo_oe), 32'd3);
    check("sb stall cycles", 32'(mo_stall), 32'd4);
    mem_op("lw 0x20", 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 5'd9, 32'h11A5_3344);

    // SW word, then LW with ignored low address bits.
    mem_op("sw 0x24", 1'b0, 1'b1, 1'b0, 32'h24, 32'hCAFE_BABE, 5'd0, 32'h0);
    check("sw be_n", 32'(mo_be), 32'h0);
    check("sw dq_o", mo_dq, 32'hCAFE_BABE);
    check("sw ram_addr", 32'(mo_addr), 32'd9);
    mem_op("lw 0x25", 1'b1, 1'b0, 1'b0, 32'h25, 32'h0, 5'd10, 32'hCAFE_BABE);

    // Read and write together: read only.
    mem_op("rd+wr", 1'b1, 1'b1, 1'b0, 32'h24, 32'h0BAD_0BAD, 5'd12, 32'hCAFE_BABE);
    check("rd+wr we_low", 32'(mo_we_low), 32'd0);
    check("rd+wr dq_oe cycles", 32'(mo_oe), 32'd0);
    check("rd+wr stall cycles", 32'(mo_stall), 32'd2);

    // Reset asserted during WR_PULSE.
    @(posedge clk); #1;
    ex_mem_write = 1'b1; ex_result = 32'h40; ex_mem_data = 32'hFFFF_FFFF;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (!ram_bus.ram_we_n) seen = 1'b1;
    end
    check("rstpulse reached pulse", 32'(seen), 32'd1);
    rst_n = 1'b0;
    drive_nop();
    @(negedge clk);
    check("rstpulse we_n", 32'(ram_bus.ram_we_n), 32'd1);
    check("rstpulse ce_n", 32'(ram_bus.ram_ce_n), 32'd1);
    check("rstpulse dq_oe", 32'(ram_bus.ram_dq_oe), 32'd0);
    check("rstpulse be_n", 32'(ram_bus.ram_be_n), 32'hF);
    check("rstpulse mem_stall", 32'(mem_stall), 32'd0);
    check("rstpulse wb_reg_write", 32'(wb_reg_write), 32'd0);
    rst_n = 1'b1;

    mem_op("lw after rst", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd11, 32'h1234_80FF);

    check("oe_n/we_n overlap cycles", 32'(overlap), 32'd0);
    check("wb_reg_write while busy", 32'(bad_wb), 32'd0);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
